watch_set_ctrl: RTL and testbench
=================================

Name: watch_set_ctrl

Overview:
- Control unit that drives the watch datapath's time-setting interface from debounced push-buttons.
- Runs a RUN / SET_SEC / SET_MIN / SET_HOUR state machine.
- Outputs: field select, edit-enable, single-cycle inc/dec pulses and a display blink flag.
- Sits between the button debouncers and the watch datapath. o_sel_pos/o_inc/o_dec/o_edit connect to the datapath's sel_pos/inc/dec/switch[1].

Parameters:
- TIMEOUT_CYCLES, 3_000_000_000, idle cycles in a SET state before auto-return to RUN (30 s at 100 MHz).
- REPEAT_DELAY, 50_000_000, hold cycles before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat pulses (0.1 s).
- BLINK_HALF, 25_000_000, half-period of o_blink in cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- i_btn_edit  input  1  debounced level; press toggles edit mode
- i_btn_next  input  1  debounced level; press advances the selected field
- i_btn_up  input  1  debounced level; increment request
- i_btn_down  input  1  debounced level; decrement request
- o_sel_pos  output  2  0 = sec, 1 = min, 2 = hour; never 3
- o_inc  output  1  one-cycle increment pulse
- o_dec  output  1  one-cycle decrement pulse
- o_edit  output  1  high in any SET state
- o_blink  output  1  selected-field blink flag for the display

Behaviour:
- Reset (rst=0, async): state RUN, o_sel_pos=0, o_inc=0, o_dec=0, o_edit=0, o_blink=0; all synchronizers, edge registers, counters cleared.
- Button inputs are asynchronous to clk. Each passes a 2-FF synchronizer, then a rising-edge detector.
- Latency: an input high before clk edge N produces its pulse/transition registered at edge N+2, so outputs change after edge N+2. Each press yields exactly one edge.
- State encoding: RUN=0, SET_SEC=1, SET_MIN=2, SET_HOUR=3.
- RUN:
  - edit edge -> SET_SEC.
  - next/up/down ignored; o_inc/o_dec held 0.
- SET_x:
  - edit edge -> RUN.
  - next edge -> SEC->MIN->HOUR->SEC (wraps).
  - up edge -> o_inc pulse; down edge -> o_dec pulse.
- Same-cycle priority: edit > next > up/down. A lower-priority edge in the same cycle is dropped, not deferred.
- Up and down both held: no pulses, and the repeat counter is held at 0.
- o_inc and o_dec are never high together, and are 0 in the cycle of any state transition.
- o_sel_pos = state-1 in SET states; 0 in RUN. o_edit = (state != RUN).
- Timeout counter:
  - Counts in SET states.
  - Cleared on any button edge, on any inc/dec pulse, and on entering a SET state.
  - Reaching TIMEOUT_CYCLES-1 -> RUN on the next edge.
  - Held at 0 in RUN.
- Blink counter:
  - Runs only in SET states.
  - o_blink toggles every BLINK_HALF cycles.
  - Cleared to 0 and o_blink forced 1 on every state change and every inc/dec pulse, so the field stays visible while being adjusted.
  - In RUN: counter 0, o_blink 0.
- Counter widths are $clog2 of the respective parameter; the timeout counter is at least 32 bits.
- Reset mid-press: everything clears. A button still held after reset release yields no edge, because the edge registers reset to 0 but the synchronizer must first see 0→1; a held button therefore produces nothing until released and re-pressed.

Optional Feature:
- Macro WATCH_SET_AUTO_REPEAT_EN.
- Defined, in a SET state with exactly one of up/down held:
  - hold counter counts from the press edge;
  - at REPEAT_DELAY cycles, emit one pulse of the held direction;
  - then one pulse every REPEAT_PERIOD cycles until release;
  - release, or any state change, clears the counter.
- Undefined: exactly one pulse per press; the hold counter is not instantiated.

Decomposition:
- Shared package watch_pkg holds:
  - state enum (RUN, SET_SEC, SET_MIN, SET_HOUR);
  - sel_pos constants SEL_SEC=0, SEL_MIN=1, SEL_HOUR=2, shared with the datapath.
- One sub-module, btn_sync_edge: 2-FF synchronizer, rising-edge detector and synchronized level output. Instantiated four times.

Test Plan:
- Use overrides TIMEOUT_CYCLES=200, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8.
1. Reset, then up press in RUN -> o_edit=0, no o_inc; edit press -> o_edit=1 and o_sel_pos=0 at edge N+2.
2. In SET_SEC, next pressed 3× -> o_sel_pos 1, 2, 0; up press -> exactly one o_inc cycle, o_dec=0.
3. edit and next rise in the same cycle while in SET_MIN -> RUN, o_sel_pos=0, no field advance.
4. In SET_HOUR, idle 200 cycles -> RUN on cycle 200, o_edit=0; a press at cycle 150 restarts the count.
5. WATCH_SET_AUTO_REPEAT_EN defined, down held 45 cycles -> o_dec pulses at press+2, +22, +27, +32, +37, +42. Undefined -> a single pulse.
6. Up and down held together -> no pulses. Reset asserted mid-hold -> all outputs 0 immediately, no pulse after reset release.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: shared types for the watch time-setting control path.
// State encoding and field-select codes are shared with the watch datapath.
package watch_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_SEC  = 2'd1,
      SET_MIN  = 2'd2,
      SET_HOUR = 2'd3
   } state_t;

   localparam logic [1:0] SEL_SEC  = 2'd0;
   localparam logic [1:0] SEL_MIN  = 2'd1;
   localparam logic [1:0] SEL_HOUR = 2'd2;

   // Field advance order SEC -> MIN -> HOUR -> SEC.
   function automatic state_t next_field(input state_t s);
      case (s)
         SET_SEC: return SET_MIN;
         SET_MIN: return SET_HOUR;
         default: return SET_SEC;
      endcase
   endfunction

   // Datapath field select for a given state; RUN reports seconds.
   function automatic logic [1:0] sel_of(input state_t s);
      case (s)
         SET_MIN:  return SEL_MIN;
         SET_HOUR: return SEL_HOUR;
         default:  return SEL_SEC;
      endcase
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer plus rising-edge detector for one
// debounced button. A button already held when reset releases is not
// reported until it has been seen low, so it cannot fake a press.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic s1, s2;
   logic v1, v2;
   logic armed;
   logic prev;

   // Synchronize, track when s2 holds a real sample, arm on first low, edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         armed <= 1'b0;
         prev  <= 1'b0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         v1   <= 1'b1;
         v2   <= v1;
         if (v2 && !s2)
            armed <= 1'b1;
         prev <= level;
      end
   end

   assign level = s2 & armed;
   assign rise  = level & ~prev;

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: RUN / SET_SEC / SET_MIN / SET_HOUR control for the watch
// time-setting interface. Optional hold-to-repeat on up/down is enabled by
// defining WATCH_SET_AUTO_REPEAT_EN.
module watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd3_000_000_000,
   parameter int unsigned REPEAT_DELAY   = 32'd50_000_000,
   parameter int unsigned REPEAT_PERIOD  = 32'd10_000_000,
   parameter int unsigned BLINK_HALF     = 32'd25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_edit,
   input  logic       i_btn_next,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   output logic [1:0] o_sel_pos,
   output logic       o_inc,
   output logic       o_dec,
   output logic       o_edit,
   output logic       o_blink
);

   localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES) > 32) ? $clog2(TIMEOUT_CYCLES) : 32;
   localparam int unsigned BL_W = ($clog2(BLINK_HALF) > 1) ? $clog2(BLINK_HALF) : 1;

   logic e_edit, e_next, e_up, e_dn;
   logic lvl_up, lvl_dn;
   logic unused_lvl_edit, unused_lvl_next;

   btn_sync_edge u_edit (.clk(clk), .rst(rst), .btn(i_btn_edit), .level(unused_lvl_edit), .rise(e_edit));
   btn_sync_edge u_next (.clk(clk), .rst(rst), .btn(i_btn_next), .level(unused_lvl_next), .rise(e_next));
   btn_sync_edge u_up   (.clk(clk), .rst(rst), .btn(i_btn_up),   .level(lvl_up),          .rise(e_up));
   btn_sync_edge u_dn   (.clk(clk), .rst(rst), .btn(i_btn_down), .level(lvl_dn),          .rise(e_dn));

   state_t          state, state_nx;
   logic [TO_W-1:0] to_cnt, to_nx;
   logic [BL_W-1:0] bl_cnt, bl_nx;
   logic            blink_nx, inc_nx, dec_nx;
   logic            any_edge, to_hit, both_held, rep_fire;

   assign any_edge  = e_edit | e_next | e_up | e_dn;
   assign both_held = lvl_up & lvl_dn;
   assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !any_edge;

`ifdef WATCH_SET_AUTO_REPEAT_EN
   localparam int unsigned HD_W = ($clog2(REPEAT_DELAY) > 1) ? $clog2(REPEAT_DELAY) : 1;

   logic [HD_W-1:0] hold_cnt, hold_nx;

   // One counter serves delay and period: after the first repeat it is
   // reloaded so the next terminal count is REPEAT_PERIOD cycles away.
   assign rep_fire = (state != RUN) && (lvl_up ^ lvl_dn) &&
                     (hold_cnt == HD_W'(REPEAT_DELAY - 1));

   // Hold counter next value: cleared on press edge, release or state change.
   always_comb begin
      hold_nx = hold_cnt + HD_W'(1);
      if (state == RUN || state_nx != state || !(lvl_up ^ lvl_dn) || e_up || e_dn)
         hold_nx = '0;
      else if (rep_fire)
         hold_nx = HD_W'(REPEAT_DELAY - REPEAT_PERIOD);
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         hold_cnt <= '0;
      else
         hold_cnt <= hold_nx;
   end
`else
   localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

   assign rep_fire = 1'b0;
`endif

   // Next state, pulses, timeout and blink counters.
   always_comb begin
      state_nx = state;
      inc_nx   = 1'b0;
      dec_nx   = 1'b0;
      if (state == RUN) begin
         if (e_edit)
            state_nx = SET_SEC;
      end else if (e_edit) begin
         state_nx = RUN;
      end else if (e_next) begin
         state_nx = next_field(state);
      end else if (to_hit) begin
         state_nx = RUN;
      end else if (!both_held) begin
         if (e_up || (rep_fire && lvl_up))
            inc_nx = 1'b1;
         else if (e_dn || (rep_fire && lvl_dn))
            dec_nx = 1'b1;
      end

      to_nx = to_cnt + TO_W'(1);
      if (state_nx == RUN || state_nx != state || any_edge || inc_nx || dec_nx)
         to_nx = '0;

      bl_nx    = bl_cnt + BL_W'(1);
      blink_nx = o_blink;
      if (state_nx == RUN) begin
         bl_nx    = '0;
         blink_nx = 1'b0;
      end else if (state_nx != state || inc_nx || dec_nx) begin
         bl_nx    = '0;
         blink_nx = 1'b1;
      end else if (bl_cnt == BL_W'(BLINK_HALF - 1)) begin
         bl_nx    = '0;
         blink_nx = ~o_blink;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         to_cnt  <= '0;
         bl_cnt  <= '0;
         o_blink <= 1'b0;
         o_inc   <= 1'b0;
         o_dec   <= 1'b0;
      end else begin
         state   <= state_nx;
         to_cnt  <= to_nx;
         bl_cnt  <= bl_nx;
         o_blink <= blink_nx;
         o_inc   <= inc_nx;
         o_dec   <= dec_nx;
      end
   end

   assign o_sel_pos = sel_of(state);
   assign o_edit    = (state != RUN);

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed bench for watch_set_ctrl with short timing
// parameters. Expectations follow the auto-repeat macro when it is defined.
module tb_watch_set_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_edit = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [1:0] o_sel_pos;
   logic       o_inc, o_dec, o_edit, o_blink;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int inc_times[$];
   int dec_times[$];

   watch_set_ctrl #(
      .TIMEOUT_CYCLES(200),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5),
      .BLINK_HALF(8)
   ) dut (
      .clk(clk), .rst(rst),
      .i_btn_edit(btn_edit), .i_btn_next(btn_next),
      .i_btn_up(btn_up), .i_btn_down(btn_down),
      .o_sel_pos(o_sel_pos), .o_inc(o_inc), .o_dec(o_dec),
      .o_edit(o_edit), .o_blink(o_blink)
   );

   always #5 clk = ~clk;

   // Cycle number = count of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Record the cycle of every inc/dec pulse.
   always @(negedge clk) begin
      if (o_inc) inc_times.push_back(cyc);
      if (o_dec) dec_times.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: btn_edit = v;
         1: btn_next = v;
         2: btn_up   = v;
         default: btn_down = v;
      endcase
   endtask

   // Press for 'hold' rising edges starting at edge pe, then settle.
   task automatic press(input int which, input int hold, output int pe);
      set_btn(which, 1'b1);
      pe = cyc + 1;
      wait_to(pe + hold - 1);
      set_btn(which, 1'b0);
      wait_to(pe + hold + 3);
   endtask

   int pe, e, n0, n1;
   int exp_dec[$];

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_edit", o_edit, 0);
      check("rst_sel", o_sel_pos, 0);
      check("rst_pulses", {o_inc, o_dec}, 0);
      check("rst_blink", o_blink, 0);
      rst = 1'b1;
      wait_to(cyc + 6);

      // 1: up ignored in RUN; edit enters SET_SEC exactly at edge N+2.
      n0 = inc_times.size();
      press(2, 3, pe);
      check("run_up_edit", o_edit, 0);
      check("run_up_noinc", inc_times.size() - n0, 0);
      btn_edit = 1'b1;
      pe = cyc + 1;
      wait_to(pe + 1);
      check("edit_lat_n1", o_edit, 0);
      wait_to(pe + 2);
      check("edit_lat_n2", o_edit, 1);
      check("edit_sel", o_sel_pos, 0);
      check("edit_blink_on", o_blink, 1);
      btn_edit = 1'b0;
      e = pe + 2;
      wait_to(e + 7);
      check("blink_hold", o_blink, 1);
      wait_to(e + 8);
      check("blink_toggle", o_blink, 0);
      wait_to(e + 12);

      // 2: next walks the fields with wrap; up gives one inc pulse.
      press(1, 3, pe);
      check("next_1", o_sel_pos, 1);
      press(1, 3, pe);
      check("next_2", o_sel_pos, 2);
      press(1, 3, pe);
      check("next_wrap", o_sel_pos, 0);
      n0 = inc_times.size();
      n1 = dec_times.size();
      press(2, 3, pe);
      check("up_one_inc", inc_times.size() - n0, 1);
      if (inc_times.size() > n0) check("up_inc_time", inc_times[n0], pe + 2);
      check("up_no_dec", dec_times.size() - n1, 0);

      // 3: edit and next rising together in SET_MIN: edit wins.
      press(1, 3, pe);
      check("to_min", o_sel_pos, 1);
      btn_edit = 1'b1;
      btn_next = 1'b1;
      wait_to(cyc + 3);
      btn_edit = 1'b0;
      btn_next = 1'b0;
      wait_to(cyc + 4);
      check("prio_edit", o_edit, 0);
      check("prio_sel", o_sel_pos, 0);

      // 4: idle timeout in SET_HOUR, then a press at 150 restarts it.
      press(0, 3, pe);
      press(1, 3, pe);
      press(1, 3, pe);
      e = pe + 2;
      check("hour_sel", o_sel_pos, 2);
      wait_to(e + 199);
      check("to_before", o_edit, 1);
      wait_to(e + 200);
      check("to_fire", o_edit, 0);
      check("to_sel", o_sel_pos, 0);
      press(0, 3, pe);
      press(1, 3, pe);
      press(1, 3, pe);
      e = pe + 2;
      wait_to(e + 147);
      press(2, 3, pe);
      wait_to(e + 200);
      check("to_restart_200", o_edit, 1);
      wait_to(e + 349);
      check("to_restart_349", o_edit, 1);
      wait_to(e + 350);
      check("to_restart_350", o_edit, 0);

      // 5: down held for 45 edges.
      press(0, 3, pe);
      n1 = dec_times.size();
      btn_down = 1'b1;
      pe = cyc + 1;
      wait_to(pe + 44);
      btn_down = 1'b0;
      wait_to(pe + 52);
      exp_dec = {pe + 2};
`ifdef WATCH_SET_AUTO_REPEAT_EN
      exp_dec = {pe + 2, pe + 22, pe + 27, pe + 32, pe + 37, pe + 42};
`endif
      check("hold_dec_count", dec_times.size() - n1, exp_dec.size());
      foreach (exp_dec[i])
         if (n1 + i < dec_times.size()) check("hold_dec_time", dec_times[n1 + i], exp_dec[i]);

      // 6: up+down together; then reset in the middle of a hold.
      n0 = inc_times.size();
      n1 = dec_times.size();
      btn_up = 1'b1;
      btn_down = 1'b1;
      wait_to(cyc + 30);
      btn_up = 1'b0;
      btn_down = 1'b0;
      wait_to(cyc + 4);
      check("both_no_inc", inc_times.size() - n0, 0);
      check("both_no_dec", dec_times.size() - n1, 0);
      check("both_still_set", o_edit, 1);
      btn_up = 1'b1;
      wait_to(cyc + 6);
      rst = 1'b0;
      #1;
      check("midrst_edit", o_edit, 0);
      check("midrst_sel", o_sel_pos, 0);
      check("midrst_pulses", {o_inc, o_dec}, 0);
      check("midrst_blink", o_blink, 0);
      btn_edit = 1'b1;
      wait_to(cyc + 2);
      rst = 1'b1;
      n0 = inc_times.size();
      wait_to(cyc + 30);
      check("held_edit_ignored", o_edit, 0);
      check("held_no_inc", inc_times.size() - n0, 0);
      btn_edit = 1'b0;
      btn_up = 1'b0;
      wait_to(cyc + 5);
      press(0, 3, pe);
      check("repress_edit", o_edit, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
